upsert_evict_fsm: RTL
=====================

// Module: upsert_evict_fsm
// PURPOSE
//  Parametrised upsert sub-FSM for the cache controller: resolves a PUT against the CAM lookup result.
//  Supports three modes (upsert / insert-only / update-only) and a configurable lookup latency.
//  When the table is full, optionally evicts a round-robin victim instead of failing.
//  Sits under the main controller FSM; drives the memory-array select/write/index lines and returns sub_cmd_t.
// PARAMETERS
//  NUM_ENTRIES  16  number of cache slots; width of used/idx vectors (>=2)
//  LOOKUP_LAT   1   cycles from enter until hit/hit_idx/used are valid (>=1)
//  EVICT_EN     1   1: full table + miss evicts victim; 0: full table + miss is an error
// PORTS
//  clk       in   1            system clock
//  rst_n     in   1            asynchronous active-low reset
//  en        in   1            advance enable; 0 freezes state, counter and victim pointer
//  enter     in   1            start new operation (overrides en; aborts any operation in flight)
//  mode      in   upsert_mode_e (2)  UPS_MODE_UPSERT / UPS_MODE_INSERT / UPS_MODE_UPDATE; sampled on enter
//  hit       in   1            key present (valid when lookup completes)
//  hit_idx   in   NUM_ENTRIES  one-hot index of matching entry
//  used      in   NUM_ENTRIES  slot-occupied vector
//  select_out out 1            1 = write targets an existing entry (value-only update)
//  write_out  out 1            single-cycle write strobe to memory array
//  evict_out  out 1            single-cycle strobe: idx_out entry is being invalidated and overwritten
//  idx_out    out NUM_ENTRIES  one-hot target slot; '0 whenever write_out=0
//  busy       out 1            operation in progress (state != IDLE)
//  cmd        out sub_cmd_t    done/error pulses to parent FSM
// BEHAVIOUR
//  - Reset: state=IDLE, lat_cnt=0, victim_ptr=0 (one-hot bit0), mode_q=UPSERT; all outputs 0.
//  - States: IDLE -> LOOKUP -> DECIDE -> {WRITE | EVICT | ERR}. EVICT -> WRITE. WRITE -> DONE -> IDLE. ERR -> IDLE.
//  - enter=1 (any state, any en): state<=LOOKUP, lat_cnt<=0, mode_q<=mode. No write is issued on abort.
//  - LOOKUP: lat_cnt increments while en; at lat_cnt==LOOKUP_LAT-1 latch hit/hit_idx/used, go DECIDE.
//  - DECIDE, on latched values:
//      hit  & mode!=INSERT          -> WRITE, tgt=hit_idx, sel=1
//      hit  & mode==INSERT          -> ERR
//      !hit & mode==UPDATE          -> ERR
//      !hit & ~&used                -> WRITE, tgt=lowest-index free slot, sel=0
//      !hit & &used & EVICT_EN      -> EVICT, tgt=victim_ptr, sel=0
//      !hit & &used & !EVICT_EN     -> ERR
//  - EVICT: evict_out=1 for one cycle, idx_out=tgt; victim_ptr rotates left by 1, wrapping bit N-1 -> bit0.
//  - WRITE: write_out=1 for exactly one cycle, idx_out=tgt, select_out=sel.
//  - DONE: cmd.done=1 one cycle. ERR: cmd.error=1 one cycle. done and error never both 1.
//  - Min latency enter->done: LOOKUP_LAT+3 cycles (+1 with eviction).
//  - en=0: state/counters hold; all strobe outputs (write_out, evict_out, cmd) forced 0; busy still valid.
//  - Strobes are decoded from the registered state (no combinational path from hit/used to outputs).
//  - Async reset mid-operation: immediate return to reset values; no partial write.
//  - hit_idx is one-hot by contract; if hit=1 and hit_idx==0, go ERR.
// STRUCTURE
//  - ctrl_types_pkg: upsert_mode_e, upsert_state_e (UPS_ST_IDLE..UPS_ST_ERR); reuse sub_cmd_t.
//  - Sub-module onehot_prio_sel #(N): lowest-set-bit one-hot select of ~used; shared with delete/get FSMs.
//  - Victim pointer is a local rotating one-hot register; no separate module.
// TESTING
//  1. Hit update: N=16, LAT=1, mode=UPSERT, hit=1, hit_idx=16'h0020 -> write_out 1 cycle, idx_out=0x0020, select_out=1, done 1 cycle later.
//  2. Insert free: hit=0, used=16'h00FF -> idx_out=16'h0100, select_out=0, done; INSERT with hit=1 -> error, no write.
//  3. Full+evict: used=16'hFFFF, hit=0, three back-to-back ops -> evict_out+write at 0x0001, 0x0002, 0x0004; 16 ops wrap to 0x0001.
//  4. Full, EVICT_EN=0 or mode=UPDATE with hit=0 -> cmd.error 1 cycle, write_out/evict_out never asserted.
//  5. LOOKUP_LAT=3: hit changes before cycle 3 ignored; sampled value used; en=0 for 2 cycles in LOOKUP delays done by exactly 2.
//  6. enter reasserted in DECIDE and rst_n pulsed in EVICT -> no write, restart/reset values; victim_ptr=0x0001 after reset.

Source files
------------

// File: rtl/ctrl_types_pkg.sv
// Shared controller types for the cache-controller sub-FSMs.
//   upsert_mode_e  : PUT resolution policy, sampled when an operation starts
//   upsert_state_e : state encoding of the upsert/evict sub-FSM
//   sub_cmd_t      : done/error pulses returned to the parent controller
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    UPS_MODE_UPSERT = 2'd0,
    UPS_MODE_INSERT = 2'd1,
    UPS_MODE_UPDATE = 2'd2
  } upsert_mode_e;

  typedef enum logic [2:0] {
    UPS_ST_IDLE   = 3'd0,
    UPS_ST_LOOKUP = 3'd1,
    UPS_ST_DECIDE = 3'd2,
    UPS_ST_EVICT  = 3'd3,
    UPS_ST_WRITE  = 3'd4,
    UPS_ST_DONE   = 3'd5,
    UPS_ST_ERR    = 3'd6
  } upsert_state_e;

  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

endpackage

// File: rtl/onehot_prio_sel.sv
// Lowest-set-bit one-hot selector.
//   req_i : candidate vector (e.g. ~used for free-slot search)
//   gnt_o : one-hot of the lowest set bit of req_i, '0 when req_i is '0
module onehot_prio_sel #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  // x & -x isolates the lowest set bit.
  always_comb begin
    gnt_o = req_i & (~req_i + N'(1));
  end

endmodule

// File: rtl/upsert_evict_fsm.sv
// Upsert sub-FSM: resolves a PUT against the CAM lookup result and drives the
// memory-array write lines. Full table + miss either evicts a round-robin victim
// or reports an error, depending on EVICT_EN.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : advance enable (0 freezes state and gates all strobes)
//   enter        : start a new operation, aborting any in flight
//   mode         : upsert / insert-only / update-only, sampled on enter
//   hit, hit_idx : CAM lookup result (one-hot index), valid LOOKUP_LAT cycles after enter
//   used         : slot-occupied vector, valid with hit
//   select_out   : write targets an existing entry
//   write_out    : single-cycle write strobe
//   evict_out    : single-cycle eviction strobe
//   idx_out      : one-hot target slot during write/evict, '0 otherwise
//   busy         : operation in progress
//   cmd          : done/error pulses to the parent FSM
module upsert_evict_fsm
  import ctrl_types_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned LOOKUP_LAT  = 1,
  parameter bit          EVICT_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   enter,
  input  upsert_mode_e           mode,
  input  logic                   hit,
  input  logic [NUM_ENTRIES-1:0] hit_idx,
  input  logic [NUM_ENTRIES-1:0] used,
  output logic                   select_out,
  output logic                   write_out,
  output logic                   evict_out,
  output logic [NUM_ENTRIES-1:0] idx_out,
  output logic                   busy,
  output sub_cmd_t               cmd
);

  localparam int unsigned CntW = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOOKUP_LAT - 1);

  upsert_state_e          state_q, state_d;
  upsert_mode_e           mode_q, mode_d;
  logic [CntW-1:0]        lat_cnt_q, lat_cnt_d;
  logic                   hit_q, hit_d;
  logic [NUM_ENTRIES-1:0] hit_idx_q, hit_idx_d;
  logic [NUM_ENTRIES-1:0] used_q, used_d;
  logic [NUM_ENTRIES-1:0] victim_q, victim_d;
  logic [NUM_ENTRIES-1:0] tgt_q, tgt_d;
  logic                   sel_q, sel_d;

  logic [NUM_ENTRIES-1:0] free_gnt;
  logic                   strobe_en;

  onehot_prio_sel #(
    .N (NUM_ENTRIES)
  ) u_free_sel (
    .req_i (~used_q),
    .gnt_o (free_gnt)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UPS_ST_IDLE;
      mode_q    <= UPS_MODE_UPSERT;
      lat_cnt_q <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      used_q    <= '0;
      victim_q  <= NUM_ENTRIES'(1);
      tgt_q     <= '0;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lat_cnt_q <= lat_cnt_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      used_q    <= used_d;
      victim_q  <= victim_d;
      tgt_q     <= tgt_d;
      sel_q     <= sel_d;
    end
  end

  // Next-state logic. Decisions use only the latched lookup result.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lat_cnt_d = lat_cnt_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    used_d    = used_q;
    victim_d  = victim_q;
    tgt_d     = tgt_q;
    sel_d     = sel_q;

    if (enter) begin
      state_d   = UPS_ST_LOOKUP;
      lat_cnt_d = '0;
      mode_d    = mode;
    end else if (en) begin
      case (state_q)
        UPS_ST_LOOKUP: begin
          if (lat_cnt_q == CntLast) begin
            hit_d     = hit;
            hit_idx_d = hit_idx;
            used_d    = used;
            state_d   = UPS_ST_DECIDE;
          end else begin
            lat_cnt_d = lat_cnt_q + CntW'(1);
          end
        end
        UPS_ST_DECIDE: begin
          if (hit_q) begin
            // A hit with an empty index breaks the one-hot contract.
            if (mode_q == UPS_MODE_INSERT || hit_idx_q == '0) begin
              state_d = UPS_ST_ERR;
            end else begin
              state_d = UPS_ST_WRITE;
              tgt_d   = hit_idx_q;
              sel_d   = 1'b1;
            end
          end else if (mode_q == UPS_MODE_UPDATE) begin
            state_d = UPS_ST_ERR;
          end else if (!(&used_q)) begin
            state_d = UPS_ST_WRITE;
            tgt_d   = free_gnt;
            sel_d   = 1'b0;
          end else if (EVICT_EN) begin
            state_d = UPS_ST_EVICT;
            tgt_d   = victim_q;
            sel_d   = 1'b0;
          end else begin
            state_d = UPS_ST_ERR;
          end
        end
        UPS_ST_EVICT: begin
          victim_d = {victim_q[NUM_ENTRIES-2:0], victim_q[NUM_ENTRIES-1]};
          state_d  = UPS_ST_WRITE;
        end
        UPS_ST_WRITE: state_d = UPS_ST_DONE;
        UPS_ST_DONE:  state_d = UPS_ST_IDLE;
        UPS_ST_ERR:   state_d = UPS_ST_IDLE;
        default:      state_d = UPS_ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state. Strobes are suppressed while frozen
  // and in the cycle a new operation aborts the current one.
  always_comb begin
    strobe_en  = en & ~enter;
    write_out  = strobe_en & (state_q == UPS_ST_WRITE);
    evict_out  = strobe_en & (state_q == UPS_ST_EVICT);
    select_out = write_out & sel_q;
    idx_out    = (write_out | evict_out) ? tgt_q : '0;
    busy       = (state_q != UPS_ST_IDLE);
    cmd.done   = strobe_en & (state_q == UPS_ST_DONE);
    cmd.error  = strobe_en & (state_q == UPS_ST_ERR);
  end

endmodule
